// File: rtl/alu_pkg.sv
// Opcode encodings shared by the ALU datapath blocks, plus a name helper for logging.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_ROL  = 4'b1000;
    localparam logic [3:0] OP_ROR  = 4'b1001;
    localparam logic [3:0] OP_ANDN = 4'b1010;

    function automatic string op_name(input logic [3:0] op);
        string name;
        case (op)
            OP_AND:  name = "AND";
            OP_OR:   name = "OR";
            OP_XOR:  name = "XOR";
            OP_NOR:  name = "NOR";
            OP_NAND: name = "NAND";
            OP_NOT:  name = "NOT";
            OP_ROL:  name = "ROL";
            OP_ROR:  name = "ROR";
            OP_ANDN: name = "ANDN";
            default: name = "ILLEGAL";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result stream between the operand sources, the logic unit and the Z path.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, opcode, operand_A, operand_B, shamt, out_ready,
        input  in_ready, out_valid, result, zero, illegal, busy
    );

    modport slave (
        input  in_valid, opcode, operand_A, operand_B, shamt, out_ready,
        output in_ready, out_valid, result, zero, illegal, busy
    );

endinterface

// File: rtl/logic_core.sv
// Combinational bitwise/rotate datapath: opcode and operands in, result and illegal flag out.
module logic_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    localparam int SW1 = SHW + 1;

    // Complementary shift amount; equals WIDTH when shamt is 0, which shifts everything out.
    logic [SW1-1:0]   rev_amt;
    logic [WIDTH-1:0] rol_val;
    logic [WIDTH-1:0] ror_val;

    assign rev_amt = SW1'(WIDTH) - SW1'(shamt);
    assign rol_val = (operand_A << shamt) | (operand_A >> rev_amt);
    assign ror_val = (operand_A >> shamt) | (operand_A << rev_amt);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (opcode)
            OP_AND:  result = operand_A & operand_B;
            OP_OR:   result = operand_A | operand_B;
            OP_XOR:  result = operand_A ^ operand_B;
            OP_NOR:  result = ~(operand_A | operand_B);
            OP_NAND: result = ~(operand_A & operand_B);
            OP_NOT:  result = ~operand_A;
            OP_ROL:  result = rol_val;
            OP_ROR:  result = ror_val;
            OP_ANDN: result = operand_A & ~operand_B;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic/rotate unit: compute at accept into stage 1, then STAGES-1 carry-only slices.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic               clock,
    input  logic               clear,
    logic_unit_pipe_if.slave   bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]  core_result;
    logic              core_illegal;
    logic              stall;
    logic              advance;

    logic              vld [STAGES];
    logic [WIDTH-1:0]  res [STAGES];
    logic              zro [STAGES];
    logic              ill [STAGES];
    logic [STAGES-1:0] vld_vec;

    logic_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .opcode    (bus.opcode),
        .operand_A (bus.operand_A),
        .operand_B (bus.operand_B),
        .shamt     (bus.shamt),
        .result    (core_result),
        .illegal   (core_illegal)
    );

    // Whole pipe freezes while the tail is blocked, so bubbles keep their slots.
    assign stall   = vld[STAGES-1] & ~bus.out_ready;
    assign advance = ~stall;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            logic             src_v;
            logic [WIDTH-1:0] src_r;
            logic             src_z;
            logic             src_i;

            if (i == 0) begin : g_head
                assign src_v = bus.in_valid;
                assign src_r = core_result;
                assign src_z = (core_result == '0);
                assign src_i = core_illegal;
            end else begin : g_body
                assign src_v = vld[i-1];
                assign src_r = res[i-1];
                assign src_z = zro[i-1];
                assign src_i = ill[i-1];
            end

            always_ff @(posedge clock or negedge clear) begin
                if (!clear) begin
                    vld[i] <= 1'b0;
                    res[i] <= '0;
                    zro[i] <= 1'b0;
                    ill[i] <= 1'b0;
                end else if (advance) begin
                    vld[i] <= src_v;
                    res[i] <= src_r;
                    zro[i] <= src_z;
                    ill[i] <= src_i;
                end
            end

            assign vld_vec[i] = vld[i];
        end
    endgenerate

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.result    = res[STAGES-1];
    assign bus.zero      = zro[STAGES-1];
    assign bus.illegal   = ill[STAGES-1];
    assign bus.busy      = |vld_vec;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table plus scoreboard, with stall and reset sequences.
module tb_logic_unit_pipe;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int SHW    = $clog2(WIDTH);
    localparam int NVEC   = 16;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    int   cyc    = 0;
    exp_t sb[$];
    vec_t vecs [NVEC];

    logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Transfers are judged at the negedge before the edge that performs them.
    always @(negedge clock) begin
        if (clear && bus.out_valid === 1'b1) begin
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    pops++;
                    check("out_result", bus.result, e.res);
                    check("out_zero", bus.zero, e.zero);
                    check("out_illegal", bus.illegal, e.ill);
                end
            end else begin
                check("stall_in_ready", bus.in_ready, 1'b0);
                if (sb.size() > 0) check("stall_hold_result", bus.result, sb[0].res);
            end
        end
    end

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        bus.in_valid  = 1'b1;
        bus.opcode    = v.op;
        bus.operand_A = v.a;
        bus.operand_B = v.b;
        bus.shamt     = v.sh;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sb.push_back('{res: v.res, zero: v.zero, ill: v.ill});
            @(posedge clock);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%s actual=not_accepted required=accepted", op_name(v.op));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   t0;
        int   p0;

        vecs[0]  = '{OP_AND,  32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{OP_AND,  32'hffffffff, 32'hffffffff, 5'd0,  32'hffffffff, 1'b0, 1'b0};
        vecs[2]  = '{OP_AND,  32'h00000000, 32'hffffffff, 5'd0,  32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{OP_AND,  32'hffffffff, 32'hffff0000, 5'd0,  32'hffff0000, 1'b0, 1'b0};
        vecs[4]  = '{OP_AND,  32'hffffffff, 32'h0000ffff, 5'd0,  32'h0000ffff, 1'b0, 1'b0};
        vecs[5]  = '{OP_OR,   32'hf0f0a5a5, 32'h0ff0ffff, 5'd0,  32'hfff0ffff, 1'b0, 1'b0};
        vecs[6]  = '{OP_XOR,  32'hf0f0a5a5, 32'h0ff0ffff, 5'd0,  32'hff005a5a, 1'b0, 1'b0};
        vecs[7]  = '{OP_NOR,  32'hf0f0a5a5, 32'h0ff0ffff, 5'd0,  32'h000f0000, 1'b0, 1'b0};
        vecs[8]  = '{OP_NAND, 32'hf0f0a5a5, 32'h0ff0ffff, 5'd0,  32'hff0f5a5a, 1'b0, 1'b0};
        vecs[9]  = '{OP_NOT,  32'hf0f0a5a5, 32'h0ff0ffff, 5'd0,  32'h0f0f5a5a, 1'b0, 1'b0};
        vecs[10] = '{OP_ANDN, 32'hf0f0a5a5, 32'h0ff0ffff, 5'd0,  32'hf0000000, 1'b0, 1'b0};
        vecs[11] = '{4'b1111, 32'hf0f0a5a5, 32'h0ff0ffff, 5'd0,  32'h00000000, 1'b1, 1'b1};
        vecs[12] = '{OP_ROL,  32'h80000001, 32'h00000000, 5'd1,  32'h00000003, 1'b0, 1'b0};
        vecs[13] = '{OP_ROR,  32'h80000001, 32'h00000000, 5'd1,  32'hc0000000, 1'b0, 1'b0};
        vecs[14] = '{OP_ROL,  32'h80000001, 32'h00000000, 5'd0,  32'h80000001, 1'b0, 1'b0};
        vecs[15] = '{OP_ROL,  32'h80000001, 32'h00000000, 5'd31, 32'hc0000000, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.operand_A = '0;
        bus.operand_B = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b1;

        // Reset held with random traffic on the inputs.
        repeat (4) begin
            @(posedge clock);
            #1;
            bus.in_valid  = 1'($urandom);
            bus.opcode    = 4'($urandom);
            bus.operand_A = $urandom;
            bus.operand_B = $urandom;
            bus.shamt     = SHW'($urandom);
        end
        @(negedge clock);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_result", bus.result, 0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_in_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clock);
        #1;

        // Single op latency.
        v = '{OP_AND, 32'h12345678, 32'hff00ff00, 5'd0, 32'h12005600, 1'b0, 1'b0};
        send(v);
        check("latency_early_valid", bus.out_valid, 1'b0);
        check("latency_busy", bus.busy, 1'b1);
        @(posedge clock);
        #1;
        check("latency_out_valid", bus.out_valid, 1'b1);
        drain("latency_drain");
        @(posedge clock);
        #1;

        // Table, streamed back to back.
        t0 = cyc;
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        check("throughput_cycles", cyc - t0, NVEC);
        drain("table_drain");
        check("idle_busy", bus.busy, 1'b0);

        // Backpressure mid-stream.
        @(posedge clock);
        #1;
        p0 = pops;
        fork
            begin
                send('{OP_OR,   32'h0000ff00, 32'h00ff0000, 5'd0, 32'h00ffff00, 1'b0, 1'b0});
                send('{OP_XOR,  32'haaaaaaaa, 32'hffffffff, 5'd0, 32'h55555555, 1'b0, 1'b0});
                send('{OP_ROL,  32'h12345678, 32'h00000000, 5'd4, 32'h23456781, 1'b0, 1'b0});
                send('{OP_ANDN, 32'hffffffff, 32'hffffffff, 5'd0, 32'h00000000, 1'b1, 1'b0});
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_pop_count", pops - p0, 4);

        // Reset with two ops in flight.
        @(posedge clock);
        #1;
        send('{OP_NOT, 32'h0f0f0f0f, 32'h0, 5'd0, 32'hf0f0f0f0, 1'b0, 1'b0});
        send('{OP_ROR, 32'h00000001, 32'h0, 5'd4, 32'h10000000, 1'b0, 1'b0});
        check("flight_busy", bus.busy, 1'b1);
        #2;
        clear = 1'b0;
        #1;
        check("async_busy", bus.busy, 1'b0);
        check("async_out_valid", bus.out_valid, 1'b0);
        check("async_result", bus.result, 0);
        sb.delete();
        @(negedge clock);
        clear = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("post_reset_out_valid", bus.out_valid, 1'b0);
        check("post_reset_busy", bus.busy, 1'b0);

        // Service resumes after reset.
        send('{OP_NAND, 32'hffffffff, 32'hffffffff, 5'd0, 32'h00000000, 1'b1, 1'b0});
        drain("resume_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
